jtsdram_bank_seq: RTL and testbench

//  Per-bank access sequencer for the SDRAM self-test core. One instance drives one bank port
//  (addr/rd/wr/din/din_m) of the SDRAM controller, walking an address range and writing or

---
 rtl/jtsdram_pkg.sv | 15 +
 rtl/jtsdram_pattern.sv | 26 ++
 rtl/jtsdram_bank_seq.sv | 156 +++++++++++++++
 tb/tb_jtsdram_bank_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtsdram_pkg.sv
// Shared definitions for the SDRAM self-test core: sequencer state encoding and pattern seed.
package jtsdram_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        CHECK   = 3'd5
    } state_t;

    localparam logic [15:0] SEED_DEFAULT = 16'h5A3C;

endpackage

// File: rtl/jtsdram_pattern.sv
// Test pattern f(a) = a[15:0] ^ SEED ^ {8'd0, a[AW-1 -: 8]} for an address and its successor.
module jtsdram_pattern
    import jtsdram_pkg::*;
#(
    parameter int          AW   = 22,
    parameter logic [15:0] SEED = SEED_DEFAULT
) (
    input  logic [AW-1:0] a,
    output logic [15:0]   f_lo,
    output logic [15:0]   f_hi
);

    // The top byte is taken left-aligned, so for AW < 8 the missing low bits read as zero.
    function automatic logic [15:0] pat(input logic [AW-1:0] x);
        logic [31:0] ext;
        ext = 32'(x) << 8;
        return 16'(32'(x)) ^ SEED ^ {8'd0, 8'(ext >> AW)};
    endfunction

    logic [AW-1:0] a_next;

    assign a_next = a + AW'(1);
    assign f_lo   = pat(a);
    assign f_hi   = pat(a_next);

endmodule

// File: rtl/jtsdram_bank_seq.sv
// Per-bank sequencer: writes (optionally) and reads back a pattern over the whole bank,
// flags mismatches and timeouts, and counts completed read passes.
module jtsdram_bank_seq
    import jtsdram_pkg::*;
#(
    parameter logic        WRITABLE = 1'b0,
    parameter int          AW       = 22,
    parameter logic [15:0] SEED     = SEED_DEFAULT,
    parameter logic [7:0]  TOUT     = 8'd255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          en,
    output logic [AW-1:0] addr,
    output logic          rd,
    output logic          wr,
    output logic [15:0]   din,
    output logic [1:0]    din_m,
    input  logic          ack,
    input  logic          rdy,
    input  logic [31:0]   data_read,
    output logic          busy,
    output logic          bad,
    output logic [7:0]    pass_cnt
);

    localparam state_t        FIRST_ST  = WRITABLE ? WR_REQ : RD_REQ;
    localparam logic [AW-1:0] ADDR_MAX  = {AW{1'b1}};
    localparam logic [7:0]    TOUT_LAST = TOUT - 8'd1;

    state_t        state_reg;
    logic [7:0]    tcnt_reg;
    logic [31:0]   rd_data_reg;
    logic          tmo_reg;
    logic          start_pend_reg;

    logic [15:0]   f_lo;
    logic [15:0]   f_hi;
    logic [AW-1:0] addr_p1;
    logic [AW-1:0] addr_p2;
    logic          tout_hit;
    logic          pass_wrap;

    jtsdram_pattern #(
        .AW   (AW),
        .SEED (SEED)
    ) u_pattern (
        .a    (addr),
        .f_lo (f_lo),
        .f_hi (f_hi)
    );

    assign addr_p1   = addr + AW'(1);
    assign addr_p2   = addr + AW'(2);
    assign tout_hit  = (tcnt_reg == TOUT_LAST);
    assign pass_wrap = (addr_p2 < addr);
    assign din_m     = 2'b00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            addr           <= '0;
            rd             <= 1'b0;
            wr             <= 1'b0;
            din            <= SEED;
            busy           <= 1'b0;
            bad            <= 1'b0;
            pass_cnt       <= 8'd0;
            tcnt_reg       <= 8'd0;
            rd_data_reg    <= 32'd0;
            tmo_reg        <= 1'b0;
            start_pend_reg <= 1'b0;
        end else begin
            // A start during an open handshake is parked until the next request slot.
            if (start && (state_reg == WR_WAIT || state_reg == RD_WAIT || state_reg == CHECK))
                start_pend_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        bad       <= 1'b0;
                        addr      <= '0;
                        state_reg <= FIRST_ST;
                    end
                end

                WR_REQ, RD_REQ: begin
                    if (start || start_pend_reg) begin
                        addr           <= '0;
                        bad            <= 1'b0;
                        start_pend_reg <= 1'b0;
                        state_reg      <= FIRST_ST;
                    end else if (en) begin
                        tcnt_reg <= 8'd0;
                        tmo_reg  <= 1'b0;
                        if (state_reg == WR_REQ) begin
                            wr        <= 1'b1;
                            din       <= f_lo;
                            state_reg <= WR_WAIT;
                        end else begin
                            rd        <= 1'b1;
                            state_reg <= RD_WAIT;
                        end
                    end
                end

                WR_WAIT: begin
                    if (ack)
                        wr <= 1'b0;
                    if (rdy || tout_hit) begin
                        wr   <= 1'b0;
                        addr <= addr_p1;
                        if (!rdy)
                            bad <= 1'b1;
                        state_reg <= (addr == ADDR_MAX) ? RD_REQ : WR_REQ;
                    end else begin
                        tcnt_reg <= tcnt_reg + 8'd1;
                    end
                end

                RD_WAIT: begin
                    if (ack)
                        rd <= 1'b0;
                    if (rdy || tout_hit) begin
                        rd          <= 1'b0;
                        rd_data_reg <= data_read;
                        tmo_reg     <= !rdy;
                        if (!rdy)
                            bad <= 1'b1;
                        state_reg <= CHECK;
                    end else begin
                        tcnt_reg <= tcnt_reg + 8'd1;
                    end
                end

                CHECK: begin
                    // A timed-out read carries no data worth comparing.
                    if (!tmo_reg && rd_data_reg != {f_hi, f_lo})
                        bad <= 1'b1;
                    addr <= addr_p2;
                    if (pass_wrap) begin
                        pass_cnt  <= pass_cnt + 8'd1;
                        state_reg <= FIRST_ST;
                    end else begin
                        state_reg <= RD_REQ;
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtsdram_bank_seq.sv
// Bench for jtsdram_bank_seq: bank model on the falling edge, request scoreboard, directed scenarios.
`timescale 1ns/1ps
module tb_jtsdram_bank_seq;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          en = 1'b1;
    logic [AW-1:0] addr;
    logic          rd;
    logic          wr;
    logic [15:0]   din;
    logic [1:0]    din_m;
    logic          ack = 1'b0;
    logic          rdy = 1'b0;
    logic [31:0]   data_read = 32'd0;
    logic          busy;
    logic          bad;
    logic [7:0]    pass_cnt;

    int nvec  = 0;
    int nfail = 0;

    typedef struct packed {
        logic        is_wr;
        logic [3:0]  a;
        logic [15:0] d;
    } req_t;

    req_t        exp_q[$];
    logic [15:0] mem [16];
    bit          corrupt_en = 1'b0;
    bit          hang_en = 1'b0;
    int          mode = 0;   // 0: ack+2 then rdy+3, 1: ack and rdy together, 2: rdy only

    always #10 clk = ~clk;

    jtsdram_bank_seq #(
        .WRITABLE (1'b1),
        .AW       (AW),
        .SEED     (16'h5A3C),
        .TOUT     (8'd8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .en        (en),
        .addr      (addr),
        .rd        (rd),
        .wr        (wr),
        .din       (din),
        .din_m     (din_m),
        .ack       (ack),
        .rdy       (rdy),
        .data_read (data_read),
        .busy      (busy),
        .bad       (bad),
        .pass_cnt  (pass_cnt)
    );

    // Hand expansion of the pattern for a 4-bit address: top byte is {a, 4'b0}.
    function automatic logic [15:0] tb_f(input logic [3:0] a);
        return 16'h5A3C ^ {12'd0, a} ^ {8'd0, a, 4'd0};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        nvec++;
        if (got !== req) begin
            nfail++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic push_pass(input bit dup0);
        req_t r;
        if (dup0) begin
            r.is_wr = 1'b1; r.a = 4'd0; r.d = tb_f(4'd0);
            exp_q.push_back(r);
        end
        for (int i = 0; i < 16; i++) begin
            r.is_wr = 1'b1; r.a = 4'(i); r.d = tb_f(4'(i));
            exp_q.push_back(r);
        end
        for (int i = 0; i < 16; i += 2) begin
            r.is_wr = 1'b0; r.a = 4'(i); r.d = 16'h0000;
            exp_q.push_back(r);
        end
    endtask

    task automatic wait_pass(input logic [7:0] n);
        int k = 0;
        while (pass_cnt !== n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("wait_pass", {24'd0, pass_cnt}, {24'd0, n});
    endtask

    task automatic wait_bad(input logic v, input string name);
        int k = 0;
        while (bad !== v && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(name, {31'd0, bad}, {31'd0, v});
    endtask

    // Bank model: reacts on the falling edge so the DUT samples stable ack/rdy/data.
    initial begin : model
        bit         active;
        int         cnt;
        logic [3:0] t_addr;
        bit         t_wr;
        active = 1'b0; cnt = 0; t_addr = 4'd0; t_wr = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        forever begin
            @(negedge clk);
            ack = 1'b0;
            rdy = 1'b0;
            if (!rst_n) begin
                active = 1'b0;
            end else begin
                if (!active && (rd || wr)) begin
                    active = 1'b1; cnt = 0; t_addr = addr; t_wr = wr;
                    if (wr) mem[addr] = (corrupt_en && addr == 4'd6) ? 16'h0000 : din;
                end else if (active) begin
                    cnt++;
                end
                if (active) begin
                    if (mode == 2) begin
                        if (cnt == 3) begin
                            rdy = 1'b1;
                            data_read = {mem[t_addr + 4'd1], mem[t_addr]};
                            active = 1'b0;
                        end
                    end else if (cnt == 2) begin
                        ack = 1'b1;
                        if (mode == 1) begin
                            rdy = 1'b1;
                            data_read = {mem[t_addr + 4'd1], mem[t_addr]};
                            active = 1'b0;
                        end else if (!t_wr && hang_en && t_addr == 4'd4) begin
                            active = 1'b0;
                        end
                    end else if (cnt == 5) begin
                        rdy = 1'b1;
                        data_read = {mem[t_addr + 4'd1], mem[t_addr]};
                        active = 1'b0;
                    end
                end
            end
        end
    end

    // Scoreboard monitor: every new request is matched against the next expected one.
    initial begin : monitor
        bit   prev;
        req_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && (rd || wr) && !prev) begin
                nvec++;
                if (exp_q.size() == 0) begin
                    nfail++;
                    $display("FAIL unexpected_req: got wr=%0b addr=%0d din=%h, required no request",
                             wr, addr, din);
                end else begin
                    e = exp_q.pop_front();
                    if (wr !== e.is_wr || addr !== e.a || (e.is_wr && din !== e.d) || din_m !== 2'b00) begin
                        nfail++;
                        $display("FAIL req: got wr=%0b addr=%0d din=%h din_m=%b, required wr=%0b addr=%0d din=%h din_m=00",
                                 wr, addr, din, din_m, e.is_wr, e.a, e.d);
                    end else begin
                        $display("req  %s addr=%0d din=%h", wr ? "WR" : "RD", addr, din);
                    end
                end
            end
            prev = rd || wr;
        end
    end

    initial begin : stim
        int k;
        int rises;
        bit p;

        repeat (3) @(negedge clk);
        check("rst_addr", {28'd0, addr}, 32'd0);
        check("rst_rd_wr", {30'd0, rd, wr}, 32'd0);
        check("rst_din", {16'd0, din}, 32'h5A3C);
        check("rst_din_m", {30'd0, din_m}, 32'd0);
        check("rst_busy_bad", {30'd0, busy, bad}, 32'd0);
        check("rst_pass_cnt", {24'd0, pass_cnt}, 32'd0);
        rst_n = 1'b1;

        // Full write pass then read pass with an ideal controller.
        push_pass(1'b0);
        push_pass(1'b0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy_on_start", {31'd0, busy}, 32'd1);
        wait_pass(8'd1);
        check("pass1_bad", {31'd0, bad}, 32'd0);

        // Word 6 stored as zero during pass 2.
        corrupt_en = 1'b1;
        wait_bad(1'b1, "bad_rise");
        check("bad_rise_addr", {28'd0, addr}, 32'd8);
        check("bad_rise_pass", {24'd0, pass_cnt}, 32'd1);
        wait_pass(8'd2);
        check("bad_sticky_p2", {31'd0, bad}, 32'd1);
        corrupt_en = 1'b0;
        push_pass(1'b1);

        // Start while the first write of pass 3 is outstanding: honoured at next request slot.
        k = 0;
        while (!(wr && addr == 4'd0) && k < 200) begin @(negedge clk); k++; end
        check("wait_wr0", {31'd0, wr}, 32'd1);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("start_latched", {31'd0, bad}, 32'd1);
        wait_bad(1'b0, "restart_clear");
        check("restart_addr", {28'd0, addr}, 32'd0);

        // Read at addr 4 never completes: timeout 8 cycles after rd rises.
        hang_en = 1'b1;
        k = 0;
        while (!(rd && addr == 4'd4) && k < 2000) begin @(negedge clk); k++; end
        check("wait_rd4", {31'd0, rd}, 32'd1);
        repeat (7) @(negedge clk);
        check("tout_not_early", {31'd0, bad}, 32'd0);
        @(negedge clk);
        check("tout_bad", {31'd0, bad}, 32'd1);
        check("tout_rd_low", {31'd0, rd}, 32'd0);
        hang_en = 1'b0;

        // en dropped with a read outstanding.
        k = 0;
        while (!rd && k < 100) begin @(negedge clk); k++; end
        check("wait_rd6", {28'd0, addr}, 32'd6);
        en = 1'b0;
        @(negedge clk);
        check("rd_held_en0", {31'd0, rd}, 32'd1);
        rises = 0;
        p = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if ((rd || wr) && !p) rises++;
            p = rd || wr;
        end
        check("no_req_en0", rises, 32'd0);
        en = 1'b1;
        @(negedge clk);
        check("rd_resume", {31'd0, rd}, 32'd1);

        // Remaining reads with ack and rdy together, next pass with rdy only.
        mode = 1;
        wait_pass(8'd3);
        mode = 2;
        push_pass(1'b0);
        wait_pass(8'd4);
        check("bad_sticky_p4", {31'd0, bad}, 32'd1);
        mode = 0;
        push_pass(1'b0);

        // Reset in the middle of a read.
        k = 0;
        while (!rd && k < 2000) begin @(negedge clk); k++; end
        check("wait_rd_p5", {28'd0, addr}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("arst_rd_wr", {30'd0, rd, wr}, 32'd0);
        check("arst_addr_din", {12'd0, addr, din}, {16'd0, 16'h5A3C});
        check("arst_busy_bad", {30'd0, busy, bad}, 32'd0);
        check("arst_pass_cnt", {24'd0, pass_cnt}, 32'd0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        push_pass(1'b0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_pass(8'd1);
        check("rerun_bad", {31'd0, bad}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
